// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: one WIDTH-bit subtract datapath shared round-robin
// between two requesters (execute SUB/CMP on port 0, condition unit on
// port 1). Operands are registered on acceptance, and the difference and
// Y86 flags are registered one cycle later. The response is held until it
// is consumed.
module sub_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cmp,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cmp,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zf,
  output logic             resp_sf,
  output logic             resp_of
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic                    cmp_p0, id_p0;
  logic                    last_grant;
  logic                    grant_id;
  logic                    accept;
  logic signed [WIDTH-1:0] diff;

  // Signed overflow of a-b: operand signs differ and the result sign
  // departs from the minuend sign.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Round-robin pick: a lone requester wins, and a tie goes to the port
  // that was not granted last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  // The reset term keeps both readys low while reset is held.
  assign req0_ready = rst_n && accept && !grant_id;
  assign req1_ready = rst_n && accept &&  grant_id;
  assign resp_valid = (state == DONE);

  // Two's-complement difference, equivalent to a + ~b + 1 modulo 2^WIDTH.
  assign diff = a_p0 - b_p0;

  // State register; reset drops any in-flight or held response at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, compute for one cycle in EXEC, and
  // hold in DONE until the consumer takes the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: capture the granted request's operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0       <= '0;
      b_p0       <= '0;
      cmp_p0     <= 1'b0;
      id_p0      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      a_p0       <= grant_id ? req1_a   : req0_a;
      b_p0       <= grant_id ? req1_b   : req0_b;
      cmp_p0     <= grant_id ? req1_cmp : req0_cmp;
      id_p0      <= grant_id;
      last_grant <= grant_id;
    end
  end

  // ---- stage p1: register the result and flags; held through DONE ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zf     <= 1'b0;
      resp_sf     <= 1'b0;
      resp_of     <= 1'b0;
    end else if (state == EXEC) begin
      resp_id     <= id_p0;
      resp_result <= cmp_p0 ? '0 : diff;
      resp_zf     <= (diff == '0);
      resp_sf     <= diff[WIDTH-1];
      resp_of     <= sub_ovf(a_p0, b_p0, diff);
    end
  end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed bench for sub_share_arbiter with hand-computed expectations.
module tb_sub_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cmp;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cmp;
  logic [63:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_result;
  logic        resp_zf, resp_sf, resp_of;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sub_share_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmp(req0_cmp),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmp(req1_cmp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zf(resp_zf), .resp_sf(resp_sf),
    .resp_of(resp_of)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the response presented in DONE.
  task automatic chk_resp(input string tag, input logic id, input logic [63:0] res,
                          input logic zf, input logic sf, input logic of_);
    chk({tag, ".valid"},  64'(resp_valid),  64'd1);
    chk({tag, ".id"},     64'(resp_id),     64'(id));
    chk({tag, ".result"}, resp_result,      res);
    chk({tag, ".zf"},     64'(resp_zf),     64'(zf));
    chk({tag, ".sf"},     64'(resp_sf),     64'(sf));
    chk({tag, ".of"},     64'(resp_of),     64'(of_));
  endtask

  // Called in IDLE with requests driven and resp_ready=1: checks the grant,
  // the response two edges later, and the return to IDLE on the third edge.
  task automatic txn(input string tag, input logic id, input logic [63:0] res,
                     input logic zf, input logic sf, input logic of_);
    chk({tag, ".rdy0"}, 64'(req0_ready), 64'(id == 1'b0));
    chk({tag, ".rdy1"}, 64'(req1_ready), 64'(id == 1'b1));
    step();
    chk({tag, ".exec_valid"}, 64'(resp_valid), 64'd0);
    step();
    chk_resp(tag, id, res, zf, sf, of_);
    step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cmp = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cmp = 1'b0;
    #2;
    // Reset state; a valid request must not see ready while reset is held.
    req0_valid = 1'b1;
    #1;
    chk("rst.valid",  64'(resp_valid), 64'd0);
    chk("rst.id",     64'(resp_id),    64'd0);
    chk("rst.result", resp_result,     64'd0);
    chk("rst.flags",  64'({resp_zf, resp_sf, resp_of}), 64'd0);
    chk("rst.rdy0",   64'(req0_ready), 64'd0);
    chk("rst.rdy1",   64'(req1_ready), 64'd0);
    req0_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Single SUB on port 0: 10 - 3.
    req0_valid = 1'b1; req0_a = 64'd10; req0_b = 64'd3; req0_cmp = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("sub.rdy0", 64'(req0_ready), 64'd1);
    chk("sub.rdy1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    chk("sub.rdy0_pulse", 64'(req0_ready), 64'd0);
    chk("sub.exec_valid", 64'(resp_valid), 64'd0);
    step();
    chk_resp("sub", 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
    step();
    chk("sub.drop_valid", 64'(resp_valid), 64'd0);
    chk("sub.keep_result", resp_result, 64'd7);

    // Fresh reset so last_grant=1, then both ports valid continuously.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd5; req0_cmp = 1'b1;
    req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'd1; req1_cmp = 1'b0;
    #1;
    txn("rr0", 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    txn("rr1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    txn("rr2", 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    txn("rr3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    req1_valid = 1'b0;

    // Overflow: most negative minus one.
    req0_a = 64'h8000_0000_0000_0000; req0_b = 64'd1; req0_cmp = 1'b0;
    #1;
    txn("ovf0", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    req0_valid = 1'b0;
    // Overflow: most positive minus (-1), on port 1.
    req1_valid = 1'b1;
    req1_a = 64'h7FFF_FFFF_FFFF_FFFF; req1_b = 64'hFFFF_FFFF_FFFF_FFFF; req1_cmp = 1'b0;
    #1;
    txn("ovf1", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);

    // CMP 3 - 9 on port 1: flags only.
    req1_a = 64'd3; req1_b = 64'd9; req1_cmp = 1'b1;
    #1;
    txn("cmp1", 1'b1, 64'd0, 1'b0, 1'b1, 1'b0);
    req1_valid = 1'b0;
    // The same CMP on port 0.
    req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd9; req0_cmp = 1'b1;
    #1;
    txn("cmp0", 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure: 20 - 5 on port 0 held for 5 cycles while port 1 waits.
    req0_a = 64'd20; req0_b = 64'd5; req0_cmp = 1'b0;
    resp_ready = 1'b0;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd1; req1_cmp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_resp("bp", 1'b0, 64'd15, 1'b0, 1'b0, 1'b0);
      chk("bp.rdy1", 64'(req1_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("bp.release_valid", 64'(resp_valid), 64'd0);
    txn("bp.next", 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
    req1_valid = 1'b0;

    // Reset asserted during EXEC.
    req0_valid = 1'b1; req0_a = 64'd40; req0_b = 64'd1; req0_cmp = 1'b0;
    resp_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("rst_exec.valid", 64'(resp_valid), 64'd0);
    #1; rst_n = 1'b1;
    step();
    chk("rst_exec.no_stale", 64'(resp_valid), 64'd0);

    // Reset asserted during DONE: valid must fall without a clock edge.
    req1_valid = 1'b1; req1_a = 64'd50; req1_b = 64'd8; req1_cmp = 1'b0;
    #1;
    step();
    req1_valid = 1'b0;
    step();
    chk("rst_done.pre_valid", 64'(resp_valid), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("rst_done.valid", 64'(resp_valid), 64'd0);
    chk("rst_done.result", resp_result, 64'd0);
    #1; rst_n = 1'b1;

    // After release, a tie goes to port 0 first.
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd4; req0_cmp = 1'b0;
    req1_valid = 1'b1; req1_a = 64'd2; req1_b = 64'd2; req1_cmp = 1'b0;
    #1;
    txn("post_rst0", 1'b0, 64'd5, 1'b0, 1'b0, 1'b0);
    txn("post_rst1", 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
